// File: rtl/cas_pkg.sv
// Shared cassette definitions: FSM states, leader byte and the 1200/2400 Hz
// tick thresholds used by both the playback and record paths.
package cas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_SYNC = 2'd2
  } cas_state_t;

  typedef enum logic [1:0] {
    CLS_ONE  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_GAP  = 2'd2
  } cas_cls_t;

  localparam logic [7:0] LEADER_BYTE   = 8'h55;
  localparam int         CAS_BIT_SPLIT = 560;
  localparam int         CAS_GAP_TICKS = 1500;

  function automatic cas_cls_t cas_classify(input logic [11:0] period,
                                            input logic [11:0] split,
                                            input logic [11:0] gap);
    cas_cls_t cls;
    if (period >= gap) cls = CLS_GAP;
    else if (period >= split) cls = CLS_ZERO;
    else cls = CLS_ONE;
    return cls;
  endfunction

endpackage

// File: rtl/cas_fifo.sv
// 4-deep x 8-bit FIFO between the demodulator and the SDRAM write port.
module cas_fifo
  import cas_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem_r [0:3];
  logic [1:0] wr_ptr_r;
  logic [1:0] rd_ptr_r;
  logic [2:0] count_r;
  logic       do_push_s;
  logic       do_pop_s;

  assign full     = (count_r == 3'd4);
  assign empty    = (count_r == 3'd0);
  assign pop_data = mem_r[rd_ptr_r];
  // A full FIFO still accepts a push when the same cycle pops an entry.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy; clr flushes and beats any push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      for (int i = 0; i < 4; i++) mem_r[i] <= 8'd0;
    end else if (clr) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 2'd1;
      end
      if (do_pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/cassette_recorder.sv
// Cassette record path: FSK demodulation of the DAC tone, byte alignment on the
// 0x55 leader and sequential byte writes of the raw CAS image into SDRAM.
module cassette_recorder
  import cas_pkg::*;
#(
  parameter int HI_TH     = 34,
  parameter int LO_TH     = 30,
  parameter int BIT_SPLIT = CAS_BIT_SPLIT,
  parameter int GAP_TICKS = CAS_GAP_TICKS,
  parameter int ADDR_W    = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              q_en,
  input  logic              motor,
  input  logic              rewind,
  input  logic [5:0]        dac_in,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  output logic              locked,
  output logic              overflow,
  output logic [ADDR_W-1:0] end_addr
);

  localparam logic [5:0]        HI_C     = 6'(HI_TH);
  localparam logic [5:0]        LO_C     = 6'(LO_TH);
  localparam logic [11:0]       SPLIT_C  = 12'(BIT_SPLIT);
  localparam logic [11:0]       GAP_C    = 12'(GAP_TICKS);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  cas_state_t        state_r;
  logic              cmp_r, cmp_nxt_s, rise_s;
  logic [10:0]       cnt_r;
  logic [11:0]       period_s;
  cas_cls_t          cls_s;
  logic              first_r, bit_ev_s, gap_ev_s;
  logic [7:0]        sh_r, sh_nxt_s;
  logic [3:0]        bcnt_r;
  logic              locked_r, push_r;
  logic [7:0]        push_data_r;
  logic              wr_req_r, overflow_r, pop_s;
  logic [ADDR_W-1:0] wr_addr_r, end_addr_r;
  logic [7:0]        wr_data_r;
  logic [7:0]        fifo_head_s;
  logic              fifo_full_s, fifo_empty_s;

  // Hysteresis comparator, period classification and bit/gap events.
  always_comb begin
    cmp_nxt_s = cmp_r;
    if (dac_in >= HI_C) cmp_nxt_s = 1'b1;
    else if (dac_in <= LO_C) cmp_nxt_s = 1'b0;
    else cmp_nxt_s = cmp_r;
    rise_s   = q_en & cmp_nxt_s & ~cmp_r;
    // The edge tick itself closes the period, hence the +1.
    period_s = {1'b0, cnt_r} + 12'd1;
    cls_s    = cas_classify(period_s, SPLIT_C, GAP_C);
    sh_nxt_s = {(cls_s == CLS_ONE), sh_r[7:1]};
    gap_ev_s = 1'b0;
    bit_ev_s = 1'b0;
    if (rise_s) begin
      gap_ev_s = (cls_s == CLS_GAP);
      bit_ev_s = (cls_s != CLS_GAP) & ~first_r;
    end else begin
      gap_ev_s = q_en & (period_s == GAP_C);
      bit_ev_s = 1'b0;
    end
    pop_s = wr_req_r & wr_ack & ~rewind;
  end

  // Comparator state and saturating period counter, both advanced on q_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_r <= 1'b0;
      cnt_r <= 11'd0;
    end else if (q_en) begin
      cmp_r <= cmp_nxt_s;
      if (rise_s) cnt_r <= 11'd0;
      else if (cnt_r != 11'h7FF) cnt_r <= cnt_r + 11'd1;
    end
  end

  // Alignment FSM: hunt for the leader, then frame every 8 bits into a push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      sh_r        <= 8'd0;
      bcnt_r      <= 4'd0;
      locked_r    <= 1'b0;
      first_r     <= 1'b1;
      push_r      <= 1'b0;
      push_data_r <= 8'd0;
    end else begin
      push_r <= 1'b0;
      if (rewind || !motor) begin
        state_r  <= ST_IDLE;
        sh_r     <= 8'd0;
        bcnt_r   <= 4'd0;
        locked_r <= 1'b0;
        first_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_HUNT;
            first_r <= 1'b1;
          end
          ST_HUNT: begin
            if (rise_s) first_r <= 1'b0;
            if (gap_ev_s) begin
              bcnt_r <= 4'd0;
            end else if (bit_ev_s) begin
              sh_r <= sh_nxt_s;
              if (bcnt_r >= 4'd7 && sh_nxt_s == LEADER_BYTE) begin
                push_r      <= 1'b1;
                push_data_r <= sh_nxt_s;
                bcnt_r      <= 4'd0;
                locked_r    <= 1'b1;
                state_r     <= ST_SYNC;
              end else if (bcnt_r != 4'd8) begin
                bcnt_r <= bcnt_r + 4'd1;
              end
            end
          end
          ST_SYNC: begin
            if (gap_ev_s) begin
              bcnt_r   <= 4'd0;
              locked_r <= 1'b0;
              state_r  <= ST_HUNT;
            end else if (bit_ev_s) begin
              sh_r <= sh_nxt_s;
              if (bcnt_r == 4'd7) begin
                push_r      <= 1'b1;
                push_data_r <= sh_nxt_s;
                bcnt_r      <= 4'd0;
              end else begin
                bcnt_r <= bcnt_r + 4'd1;
              end
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  cas_fifo u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (rewind),
    .push      (push_r),
    .push_data (push_data_r),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // SDRAM write handshake, address tracking and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_req_r   <= 1'b0;
      wr_addr_r  <= '0;
      end_addr_r <= '0;
      wr_data_r  <= 8'd0;
      overflow_r <= 1'b0;
    end else if (rewind) begin
      wr_req_r   <= 1'b0;
      wr_addr_r  <= '0;
      end_addr_r <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_r && fifo_full_s && !pop_s) overflow_r <= 1'b1;
      if (pop_s) begin
        wr_req_r   <= 1'b0;
        wr_addr_r  <= wr_addr_r + ADDR_ONE;
        end_addr_r <= end_addr_r + ADDR_ONE;
      end else if (!wr_req_r && !fifo_empty_s) begin
        wr_req_r  <= 1'b1;
        wr_data_r <= fifo_head_s;
      end
    end
  end

  assign wr_req   = wr_req_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign locked   = locked_r;
  assign overflow = overflow_r;
  assign end_addr = end_addr_r;

endmodule

// File: tb/tb_cassette_recorder.sv
// Directed bench for cassette_recorder: synthesizes FSK periods on dac_in and
// checks SDRAM writes against a scoreboard of expected address/data pairs.
module tb_cassette_recorder;

  localparam int ADDR_W = 25;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n, q_en, motor, rewind, wr_ack;
  logic [5:0]        dac_in;
  logic              wr_req, locked, overflow;
  logic [ADDR_W-1:0] wr_addr, end_addr;
  logic [7:0]        wr_data;

  int                tests = 0;
  int                fails = 0;
  wr_t               sb[$];
  logic [ADDR_W-1:0] next_addr;
  bit                slow = 1'b0;

  cassette_recorder #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .q_en     (q_en),
    .motor    (motor),
    .rewind   (rewind),
    .dac_in   (dac_in),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .locked   (locked),
    .overflow (overflow),
    .end_addr (end_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One Q tick; in slow mode an extra clock with q_en low and a clearing
  // level on dac_in that the comparator must ignore.
  task automatic tick(input logic [5:0] d);
    dac_in = d;
    q_en   = 1'b1;
    @(posedge clk); #1;
    if (slow) begin
      q_en   = 1'b0;
      dac_in = 6'd0;
      @(posedge clk); #1;
      dac_in = d;
      q_en   = 1'b1;
    end
  endtask

  // One tone cycle of p ticks ending on a rising edge; mid-band values hold.
  task automatic cyc(input int p);
    int h;
    h = p / 2;
    for (int i = 0; i < p; i++) begin
      if (i < h) tick(6'd33);
      else if (i == h) tick(6'd30);
      else if (i < p - 1) tick(6'd31);
      else tick(6'd34);
    end
  endtask

  task automatic start_timing();
    tick(6'd0);
    tick(6'd0);
    tick(6'd34);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_write);
    wr_t e;
    for (int i = 0; i < 8; i++) cyc(b[i] ? 373 : 746);
    if (expect_write) begin
      e.addr = next_addr;
      e.data = b;
      sb.push_back(e);
      next_addr = next_addr + 1'b1;
    end
  endtask

  task automatic ack_write(input string tag);
    wr_t e;
    int  n;
    n = 0;
    while (wr_req !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) e = sb.pop_front();
    else e = '1;
    chk({tag, "_req"}, 32'(wr_req), 32'd1);
    chk({tag, "_addr"}, 32'(wr_addr), 32'(e.addr));
    chk({tag, "_data"}, 32'(wr_data), 32'(e.data));
    wr_ack = 1'b1;
    @(posedge clk); #1;
    wr_ack = 1'b0;
    chk({tag, "_drop"}, 32'(wr_req), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; q_en = 1'b1; motor = 1'b0; rewind = 1'b0;
    wr_ack = 1'b0; dac_in = 6'd0; next_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_end_addr", 32'(end_addr), 32'd0);
    reset_n = 1'b1;

    // Leader lock and tick-to-request latency.
    motor = 1'b1;
    repeat (4) tick(6'd0);
    tick(6'd34);
    chk("hunt_unlocked", 32'(locked), 32'd0);
    send_byte(8'h55, 1'b1);
    chk("leader_locked", 32'(locked), 32'd1);
    chk("lat_0clk", 32'(wr_req), 32'd0);
    @(posedge clk); #1;
    chk("lat_1clk", 32'(wr_req), 32'd0);
    @(posedge clk); #1;
    chk("lat_2clk", 32'(wr_req), 32'd1);
    ack_write("leader");

    // Data bytes after lock.
    send_byte(8'h3C, 1'b1);
    ack_write("byte_3c");
    send_byte(8'hFF, 1'b1);
    ack_write("byte_ff");
    chk("end_addr_3", 32'(end_addr), 32'd3);
    chk("wr_addr_3", 32'(wr_addr), 32'd3);

    // Period boundaries: 5x one, 559 -> 1, 560 -> 0, 1499 -> 0 gives 0x3F.
    slow = 1'b1;
    repeat (5) cyc(373);
    cyc(559);
    cyc(560);
    cyc(1499);
    begin
      wr_t e;
      e.addr = next_addr;
      e.data = 8'h3F;
      sb.push_back(e);
      next_addr = next_addr + 1'b1;
    end
    chk("split_still_locked", 32'(locked), 32'd1);
    cyc(1500);
    chk("gap_unlocked", 32'(locked), 32'd0);
    slow = 1'b0;
    ack_write("split_byte");

    // Rewind, relock, then overflow with ack held low.
    rewind = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rw1_wr_addr", 32'(wr_addr), 32'd0);
    chk("rw1_end_addr", 32'(end_addr), 32'd0);
    rewind = 1'b0;
    next_addr = '0;
    start_timing();
    send_byte(8'h55, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hFD, 1'b1);
    send_byte(8'hFB, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_addr_held", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 4; i++) ack_write($sformatf("ovf_%0d", i));
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_drained", 32'(wr_req), 32'd0);
    chk("ovf_end_addr", 32'(end_addr), 32'd4);

    // Rewind in the same cycle as an ack and a push.
    send_byte(8'hFF, 1'b1);
    send_byte(8'hF0, 1'b0);
    rewind = 1'b1;
    wr_ack = 1'b1;
    @(posedge clk); #1;
    wr_ack = 1'b0;
    chk("rw2_wr_req", 32'(wr_req), 32'd0);
    chk("rw2_wr_addr", 32'(wr_addr), 32'd0);
    chk("rw2_end_addr", 32'(end_addr), 32'd0);
    chk("rw2_overflow", 32'(overflow), 32'd0);
    chk("rw2_locked", 32'(locked), 32'd0);
    rewind = 1'b0;
    sb.delete();
    next_addr = '0;
    start_timing();
    send_byte(8'h55, 1'b1);
    ack_write("relock");
    repeat (3) begin @(posedge clk); #1; end
    chk("rw2_flushed", 32'(wr_req), 32'd0);

    // Motor off mid-byte: partial byte dropped, pending byte still written.
    send_byte(8'h0F, 1'b1);
    repeat (4) cyc(373);
    motor = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("motor_off_unlocked", 32'(locked), 32'd0);
    ack_write("drain");
    repeat (4) begin @(posedge clk); #1; end
    chk("motor_off_idle_req", 32'(wr_req), 32'd0);
    chk("motor_off_end_addr", 32'(end_addr), 32'd2);
    wr_ack = 1'b1;
    @(posedge clk); #1;
    wr_ack = 1'b0;
    chk("stray_ack_end_addr", 32'(end_addr), 32'd2);
    chk("stray_ack_wr_addr", 32'(wr_addr), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
